// File: rtl/axis_mux_frame_sel.sv
// Selector controller for a two-input AXI4-Stream video mux: moves the mux
// select only on a frame boundary of the active source, with a stall timeout.
module axis_mux_frame_sel #(
   parameter int LINES    = 1080,
   parameter int TIMEOUT  = 1 << 20,
   parameter bit INIT_SEL = 1'b0
) (
   input  logic                       aclk,
   input  logic                       reset,
   input  logic                       sel_req,
   input  logic                       s0_tvalid,
   input  logic                       s0_tuser,
   input  logic                       s0_tlast,
   input  logic                       s1_tvalid,
   input  logic                       s1_tuser,
   input  logic                       s1_tlast,
   input  logic                       m_tready,
   output logic                       selector,
   output logic                       busy,
   output logic                       switch_done,
   output logic                       timeout_flag,
   output logic [$clog2(LINES+1)-1:0] line_cnt
);

   localparam int CW = $clog2(LINES + 1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST_LINE = CW'(LINES - 1);
   localparam logic [CW-1:0] MAX_LINE  = CW'(LINES);
   localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      LOCKED,
      WAIT_EOF,
      WAIT_SOF
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic            r_sel;
   logic            r_done;
   logic            r_tflag;
   logic [CW-1:0]   r_line;
   logic [TW-1:0]   r_tcnt;

   logic            w_valid;
   logic            w_user;
   logic            w_last;
   logic            w_beat;
   logic            w_sof;
   logic            w_eol;
   logic [CW-1:0]   w_line_idx;
   logic            w_last_line;
   logic            w_toggle;
   logic            w_force;
   logic            w_done;

   // Beat qualification always follows the currently selected source.
   always_comb begin
      w_valid    = r_sel ? s1_tvalid : s0_tvalid;
      w_user     = r_sel ? s1_tuser  : s0_tuser;
      w_last     = r_sel ? s1_tlast  : s0_tlast;
      w_beat     = w_valid & m_tready;
      w_sof      = w_beat & w_user;
      w_eol      = w_beat & w_last;
      // An SOF beat that also ends a line belongs to line 0 of the new frame.
      w_line_idx = w_sof ? '0 : r_line;
      w_last_line = w_eol && ((LINES == 1) || (w_line_idx == LAST_LINE));
   end

   always_comb begin
      w_state_next = r_state;
      w_toggle     = 1'b0;
      w_force      = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         LOCKED: begin
            if (sel_req != r_sel)
               w_state_next = WAIT_EOF;
         end
         WAIT_EOF: begin
            // Revert beats end-of-frame; end-of-frame beats timeout.
            if (sel_req == r_sel) begin
               w_state_next = LOCKED;
            end else if (w_last_line) begin
               w_toggle     = 1'b1;
               w_state_next = WAIT_SOF;
            end else if (r_tcnt == T_LAST) begin
               w_toggle     = 1'b1;
               w_force      = 1'b1;
               w_state_next = WAIT_SOF;
            end
         end
         WAIT_SOF: begin
            if (w_sof) begin
               w_done       = 1'b1;
               w_state_next = LOCKED;
            end
         end
         default: w_state_next = LOCKED;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         r_state <= LOCKED;
         r_sel   <= INIT_SEL;
         r_done  <= 1'b0;
         r_tflag <= 1'b0;
         r_line  <= '0;
         r_tcnt  <= '0;
      end else begin
         r_state <= w_state_next;
         r_done  <= w_done;
         if (w_toggle)
            r_sel <= ~r_sel;
         if (w_force)
            r_tflag <= 1'b1;

         if (r_state == WAIT_EOF)
            r_tcnt <= r_tcnt + 1'b1;
         else
            r_tcnt <= '0;

         // Long frames saturate so no switch happens until the next SOF.
         if (w_toggle)
            r_line <= '0;
         else if (w_sof)
            r_line <= w_last ? CW'(1) : '0;
         else if (w_eol && (r_line != MAX_LINE))
            r_line <= r_line + 1'b1;
      end
   end

   assign selector     = r_sel;
   assign busy         = (r_state != LOCKED);
   assign switch_done  = r_done;
   assign timeout_flag = r_tflag;
   assign line_cnt     = r_line;

endmodule

// File: doc/axis_mux_frame_sel.md
# axis_mux_frame_sel

Frame-boundary selector controller for the two-input AXI4-Stream video mux. It accepts a level-type source request and drives the mux `selector` input. A switch happens only after the active stream completes a full frame, so downstream video IP never sees a torn frame. It taps the tvalid/tuser/tlast of both sources plus the shared downstream tready, and reports switch progress, completion and stall-timeout status.

## Interface
Parameters:
- `LINES`, 1080: lines (tlast beats) per frame; must be ≥1.
- `TIMEOUT`, 2^20: cycles of waiting for end-of-frame before a forced switch; must be ≥1.
- `INIT_SEL`, 0: selector value after reset.

Ports:
- `aclk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sel_req`  in  1  requested source (0/1), level, sampled every cycle.
- `s0_tvalid`, `s0_tuser`, `s0_tlast`  in  1 each  tap of source 0.
- `s1_tvalid`, `s1_tuser`, `s1_tlast`  in  1 each  tap of source 1.
- `m_tready`  in  1  downstream tready of the mux output.
- `selector`  out  1  registered mux select.
- `busy`  out  1  high while a switch is pending or in progress (state ≠ LOCKED).
- `switch_done`  out  1  one-cycle pulse when the new source's first SOF beat is accepted.
- `timeout_flag`  out  1  sticky; set on a forced switch; cleared only by reset.
- `line_cnt`  out  $clog2(LINES+1)  lines completed in the current frame of the selected source.

## Operation
- Beat definition: selected source's tvalid & `m_tready`. SOF beat is a beat with tuser=1. EOL beat is a beat with tlast=1.
- Line counter (all states):
  - An SOF beat loads 0, or 1 if that beat also has tlast.
  - Otherwise each EOL beat increments the counter, saturating at LINES.
  - Reloads to 0 whenever `selector` changes.
- FSM states:
  - LOCKED: `busy`=0.
    - If `sel_req` ≠ `selector`, go to WAIT_EOF.
    - Clear the timeout counter.
  - WAIT_EOF:
    - If `sel_req` = `selector` again, abort to LOCKED with no switch.
    - An EOL beat with `line_cnt` = LINES-1 (the last line of the frame) toggles `selector` on the next edge and goes to WAIT_SOF.
    - If the timeout counter reaches TIMEOUT-1, force the same toggle, set `timeout_flag`, and go to WAIT_SOF.
    - The timeout counter increments every cycle in this state.
  - WAIT_SOF: `selector` now equals the target.
    - On an SOF beat of the new source, pulse `switch_done` and go to LOCKED.
    - `sel_req` changes here are ignored until LOCKED is reached. LOCKED then re-evaluates and may start a new switch.
- A frame shorter than LINES (early SOF) resets the counter, so the switch waits for a full frame. A frame longer than LINES saturates the counter, so no switch occurs until the next SOF.
- LINES=1: every EOL beat is end-of-frame.

## Timing
- Reset values: `selector`=INIT_SEL, `busy`=0, `switch_done`=0, `timeout_flag`=0, `line_cnt`=0, state=LOCKED.
- Reset asserted mid-switch returns to reset values on the next edge. No pulse is issued.
- A `sel_req` change is seen in cycle N; `busy`=1 from N+1.
- Last-line EOL beat in cycle E gives `selector` toggled from E+1.
  - The mux is combinational, so the beat at E+1 comes from the new source.
  - The last beat of the old frame is the final old-source beat.
- New-source SOF beat in cycle S gives `switch_done`=1 in S+1 only, and `busy`=0 from S+1.
- Simultaneous EOL-last beat and `sel_req` revert in WAIT_EOF: the abort wins and `selector` is unchanged.
- Simultaneous timeout and qualifying EOL: a normal switch, and `timeout_flag` is not set.
- Beats with `m_tready`=0 are ignored by all counters.

## Test plan
- LINES=4, INIT_SEL=0, src0 streaming 4-line frames. Raise `sel_req` mid-line 2 → `busy`=1 next cycle; `selector`=1 the cycle after the 4th EOL beat; `switch_done` pulse the cycle after src1's SOF beat; `busy`=0 with it.
- Raise `sel_req` during line 1, drop it during line 3 → abort, `selector` stays 0, `busy` back to 0, no `switch_done`.
- Src0 stalls (tvalid=0) after the request, TIMEOUT=16 → `selector` toggles 16 cycles after entering WAIT_EOF; `timeout_flag`=1 and remains set until reset.
- Src0 sends a 2-line frame, then SOF, then 4 lines, with the request pending → no switch after the short frame; switch after the 4th EOL of the full frame.
- `m_tready` low during the last-line tlast → no switch until that beat is accepted with `m_tready`=1.
- Assert `reset` during WAIT_SOF → `selector`=INIT_SEL, `busy`=0, `line_cnt`=0, `timeout_flag`=0, no `switch_done`.
